// File: rtl/chip8_fetch_if.sv
// Fetch-unit bus bundle: the opcode handshake toward the decoder, the
// PC control inputs, and the byte-wide memory port.
interface chip8_fetch_if;
  logic        pc_load;
  logic [11:0] pc_load_value;
  logic        pc_skip;
  logic        opcode_ready;
  logic        opcode_valid;
  logic [15:0] opcode;
  logic [11:0] opcode_pc;
  logic [11:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem_rdata;

  modport master (
    input  pc_load, pc_load_value, pc_skip, opcode_ready, mem_rdata,
    output opcode_valid, opcode, opcode_pc, mem_address, mem_read,
           mem_write, mem_data_out
  );

  modport slave (
    output pc_load, pc_load_value, pc_skip, opcode_ready, mem_rdata,
    input  opcode_valid, opcode, opcode_pc, mem_address, mem_read,
           mem_write, mem_data_out
  );
endinterface

// File: rtl/chip8_fetch.sv
// CHIP-8 instruction fetch: reads two bytes at pc from a one-cycle-latency
// memory, presents the 16-bit opcode with a valid/ready handshake, and
// advances the PC by 2 (or 4 on skip). pc_load redirects at any time.
module chip8_fetch #(
  parameter logic [11:0] RESET_PC = 12'h200
) (
  input logic          clk,
  input logic          rst,
  chip8_fetch_if.master bus
);

  typedef enum logic [1:0] {FETCH_HI, FETCH_LO, CAPTURE, PRESENT} state_t;

  state_t      state, state_nx;
  logic [11:0] pc;
  logic [11:0] addr;
  logic [7:0]  hi_byte;
  logic        valid;
  logic [15:0] opcode;
  logic [11:0] opcode_pc;
  logic        xfer;

  // The memory port is read-only from this block.
  assign bus.mem_read     = 1'b1;
  assign bus.mem_write    = 1'b0;
  assign bus.mem_data_out = 8'h00;

  assign bus.mem_address  = addr;
  assign bus.opcode_valid = valid;
  assign bus.opcode       = opcode;
  assign bus.opcode_pc    = opcode_pc;

  assign xfer = valid && bus.opcode_ready;

  // Next state and memory address.
  always_comb begin
    state_nx = state;
    addr     = pc;
    if (bus.pc_load) begin
      state_nx = FETCH_HI;
    end else begin
      case (state)
        FETCH_HI: state_nx = FETCH_LO;
        FETCH_LO: begin
          addr     = pc + 12'd1;
          state_nx = CAPTURE;
        end
        CAPTURE:  state_nx = PRESENT;
        PRESENT:  if (xfer) state_nx = FETCH_HI;
        default:  state_nx = FETCH_HI;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= FETCH_HI;
    else     state <= state_nx;
  end

  // PC, staged high byte and presented opcode. The high byte is staged
  // separately so opcode stays untouched until the whole word is in.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc        <= RESET_PC;
      hi_byte   <= 8'h00;
      valid     <= 1'b0;
      opcode    <= 16'h0000;
      opcode_pc <= 12'h000;
    end else if (bus.pc_load) begin
      pc    <= bus.pc_load_value;
      valid <= 1'b0;
    end else begin
      case (state)
        FETCH_LO: hi_byte <= bus.mem_rdata;
        CAPTURE: begin
          opcode    <= {hi_byte, bus.mem_rdata};
          opcode_pc <= pc;
          valid     <= 1'b1;
        end
        PRESENT: if (xfer) begin
          valid <= 1'b0;
          pc    <= pc + (bus.pc_skip ? 12'd4 : 12'd2);
        end
        default: ;
      endcase
    end
  end

endmodule
